// File: rtl/regfile_pkg.sv
// Shared widths and enumerations for the register-file writeback arbiter.
package regfile_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } gnt_e;

   typedef enum logic {
      PTR_A = 1'b0,
      PTR_B = 1'b1
   } ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus, register-file write port and read-hazard flags.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) ();

   logic          a_valid;
   logic [AW-1:0] a_wn;
   logic [DW-1:0] a_d;
   logic          a_ready;

   logic          b_valid;
   logic [AW-1:0] b_wn;
   logic [DW-1:0] b_d;
   logic          b_ready;

   logic          we;
   logic [AW-1:0] wn;
   logic [DW-1:0] d;

   logic [AW-1:0] rna;
   logic [AW-1:0] rnb;
   logic          pend_a;
   logic          pend_b;

   logic          idle;

   modport slave (
      input  a_valid, a_wn, a_d, b_valid, b_wn, b_d, rna, rnb,
      output a_ready, b_ready, we, wn, d, pend_a, pend_b, idle
   );

   modport master (
      output a_valid, a_wn, a_d, b_valid, b_wn, b_d, rna, rnb,
      input  a_ready, b_ready, we, wn, d, pend_a, pend_b, idle
   );

endinterface

// File: rtl/wb_slot.sv
// One-deep pending write buffer for a single requester. Accepts a new
// request whenever empty or when its current entry is granted this cycle.
module wb_slot
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          valid,
   input  logic [AW-1:0] wn_in,
   input  logic [DW-1:0] d_in,
   input  logic          grant,
   output logic          ready,
   output logic          occ,
   output logic [AW-1:0] wn,
   output logic [DW-1:0] d
);

   logic          occ_q, occ_d;
   logic [AW-1:0] wn_q, wn_d;
   logic [DW-1:0] d_q, d_d;
   logic          load;

   // Load on handshake; a granted entry reloaded at the same edge keeps the new request.
   always_comb begin
      ready = !occ_q || grant;
      load  = valid && ready;
      occ_d = load || (occ_q && !grant);
      wn_d  = load ? wn_in : wn_q;
      d_d   = load ? d_in  : d_q;
   end

   // Entry storage.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         occ_q <= 1'b0;
         wn_q  <= '0;
         d_q   <= '0;
      end else begin
         occ_q <= occ_d;
         wn_q  <= wn_d;
         d_q   <= d_d;
      end
   end

   assign occ = occ_q;
   assign wn  = wn_q;
   assign d   = d_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of a register file whose single
// write port is sampled on negedge clk.
//
// Round-robin pointer states:
//   state | meaning
//   PTR_A | A wins when both entries are occupied
//   PTR_B | B wins when both entries are occupied
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic                  clk,
   input  logic                  clrn,
   regfile_wb_arbiter_if.slave   bus
);

   logic          occ_a, occ_b;
   logic [AW-1:0] wn_a, wn_b;
   logic [DW-1:0] d_a, d_b;

   gnt_e          gnt;
   ptr_e          ptr_q, ptr_d;

   logic          we_q, we_d;
   logic [AW-1:0] wn_q, wn_d;
   logic [DW-1:0] d_q, d_d;

   logic [AW-1:0] sel_wn;
   logic [DW-1:0] sel_d;

   wb_slot #(.DW(DW), .AW(AW)) u_slot_a (
      .clk   (clk),
      .clrn  (clrn),
      .valid (bus.a_valid),
      .wn_in (bus.a_wn),
      .d_in  (bus.a_d),
      .grant (gnt == GNT_A),
      .ready (bus.a_ready),
      .occ   (occ_a),
      .wn    (wn_a),
      .d     (d_a)
   );

   wb_slot #(.DW(DW), .AW(AW)) u_slot_b (
      .clk   (clk),
      .clrn  (clrn),
      .valid (bus.b_valid),
      .wn_in (bus.b_wn),
      .d_in  (bus.b_d),
      .grant (gnt == GNT_B),
      .ready (bus.b_ready),
      .occ   (occ_b),
      .wn    (wn_b),
      .d     (d_b)
   );

   // Grant selection and pointer next state; pointer only moves on a grant.
   always_comb begin
      gnt    = GNT_NONE;
      ptr_d  = ptr_q;
      sel_wn = wn_a;
      sel_d  = d_a;
      if (occ_a && occ_b) begin
         gnt = (ptr_q == PTR_A) ? GNT_A : GNT_B;
      end else if (occ_a) begin
         gnt = GNT_A;
      end else if (occ_b) begin
         gnt = GNT_B;
      end
      if (gnt == GNT_A) begin
         ptr_d = PTR_B;
      end else if (gnt == GNT_B) begin
         ptr_d  = PTR_A;
         sel_wn = wn_b;
         sel_d  = d_b;
      end
   end

   // Output stage next values; a grant to r0 is consumed but never writes.
   always_comb begin
      we_d = 1'b0;
      wn_d = wn_q;
      d_d  = d_q;
      if (gnt != GNT_NONE) begin
         we_d = (sel_wn != '0);
         wn_d = sel_wn;
         d_d  = sel_d;
      end
   end

   // Pointer and registered write port.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ptr_q <= PTR_A;
         we_q  <= 1'b0;
         wn_q  <= '0;
         d_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         we_q  <= we_d;
         wn_q  <= wn_d;
         d_q   <= d_d;
      end
   end

   // Read-hazard flags against buffered entries and the issuing write.
   always_comb begin
      bus.pend_a = (bus.rna != '0) &&
                   ((occ_a && (wn_a == bus.rna)) ||
                    (occ_b && (wn_b == bus.rna)) ||
                    (we_q  && (wn_q == bus.rna)));
      bus.pend_b = (bus.rnb != '0) &&
                   ((occ_a && (wn_a == bus.rnb)) ||
                    (occ_b && (wn_b == bus.rnb)) ||
                    (we_q  && (wn_q == bus.rnb)));
   end

   assign bus.we   = we_q;
   assign bus.wn   = wn_q;
   assign bus.d    = d_q;
   assign bus.idle = !occ_a && !occ_b && !we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write-port scoreboard and a
// negedge register-file model.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] d;
   } wr_t;

   logic clk;
   logic clrn;
   int   checks;
   int   errors;
   wr_t  exp_q[$];
   logic [31:0] regs [32];

   regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

   regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [4:0] wn, input logic [31:0] d);
      wr_t e;
      e.wn = wn;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.a_wn    = '0;
      bus.b_wn    = '0;
      bus.a_d     = '0;
      bus.b_d     = '0;
   endtask

   task automatic do_reset();
      step();
      clrn = 1'b0;
      repeat (2) step();
      clrn = 1'b1;
      @(negedge clk);
      chk("post_reset_a_ready", {31'b0, bus.a_ready}, 32'd1);
      chk("post_reset_b_ready", {31'b0, bus.b_ready}, 32'd1);
      chk("post_reset_idle",    {31'b0, bus.idle},    32'd1);
      chk("post_reset_we",      {31'b0, bus.we},      32'd0);
   endtask

   // Scoreboard monitor and register-file model on the write port.
   always @(negedge clk) begin
      if (clrn === 1'b1 && bus.we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got wn %0d d %h expected no write", bus.wn, bus.d);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_wn", {27'b0, bus.wn}, {27'b0, e.wn});
            chk("write_d",  bus.d, e.d);
         end
         if (bus.wn != 5'd0) regs[bus.wn] = bus.d;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic fa, fb;
      int   ia, ib;
      logic [31:0] a_data [4];
      logic [31:0] b_data [4];

      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      clrn   = 1'b0;
      quiet();
      bus.rna = 5'd3;
      bus.rnb = 5'd0;

      // Reset state while held
      #2;
      chk("reset_we",      {31'b0, bus.we},      32'd0);
      chk("reset_idle",    {31'b0, bus.idle},    32'd1);
      chk("reset_a_ready", {31'b0, bus.a_ready}, 32'd1);
      chk("reset_pend_a",  {31'b0, bus.pend_a},  32'd0);
      repeat (2) step();
      clrn = 1'b1;

      // Single write with one-posedge latency
      step();
      bus.a_valid = 1'b1;
      bus.a_wn    = 5'd3;
      bus.a_d     = 32'h1234_5678;
      push(5'd3, 32'h1234_5678);
      step();
      quiet();
      @(negedge clk);
      chk("single_we_not_yet", {31'b0, bus.we},   32'd0);
      chk("single_pend_a",     {31'b0, bus.pend_a}, 32'd1);
      step();
      @(negedge clk);
      chk("single_we", {31'b0, bus.we}, 32'd1);
      repeat (2) step();
      chk("readback_r3", regs[3], 32'h1234_5678);

      // Contention: alternating grants A, B, A, B
      do_reset();
      a_data = '{32'hA, 32'hA1, 32'hA2, 32'hA3};
      b_data = '{32'hB, 32'hB1, 32'hB2, 32'hB3};
      for (int k = 0; k < 4; k++) begin
         push(5'd4, a_data[k]);
         push(5'd5, b_data[k]);
      end
      step();
      ia = 0;
      ib = 0;
      bus.a_valid = 1'b1; bus.a_wn = 5'd4; bus.a_d = a_data[0];
      bus.b_valid = 1'b1; bus.b_wn = 5'd5; bus.b_d = b_data[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("cont_a_ready_c0", {31'b0, bus.a_ready}, 32'd1);
            chk("cont_b_ready_c0", {31'b0, bus.b_ready}, 32'd1);
         end else if (c <= 6) begin
            chk("cont_a_ready", {31'b0, bus.a_ready}, {31'b0, logic'(c % 2 == 1)});
            chk("cont_b_ready", {31'b0, bus.b_ready}, {31'b0, logic'(c % 2 == 0)});
         end
         fa = bus.a_valid && bus.a_ready;
         fb = bus.b_valid && bus.b_ready;
         step();
         if (fa) begin
            ia++;
            if (ia == 4) bus.a_valid = 1'b0;
            else         bus.a_d = a_data[ia];
         end
         if (fb) begin
            ib++;
            if (ib == 4) bus.b_valid = 1'b0;
            else         bus.b_d = b_data[ib];
         end
      end
      quiet();
      step();
      chk("cont_a_accepts", ia, 32'd4);
      chk("cont_b_accepts", ib, 32'd4);
      chk("cont_idle", {31'b0, bus.idle}, 32'd1);

      // Write to r0 is consumed without asserting we
      do_reset();
      step();
      bus.b_valid = 1'b1;
      bus.b_wn    = 5'd0;
      bus.b_d     = 32'hFFFF_FFFF;
      step();
      quiet();
      @(negedge clk);
      chk("r0_buffered_idle", {31'b0, bus.idle}, 32'd0);
      step();
      @(negedge clk);
      chk("r0_we",   {31'b0, bus.we},   32'd0);
      chk("r0_idle", {31'b0, bus.idle}, 32'd1);

      // Read hazard tracking through buffer and output stage
      do_reset();
      bus.rna = 5'd7;
      bus.rnb = 5'd0;
      step();
      bus.a_valid = 1'b1; bus.a_wn = 5'd7; bus.a_d = 32'h77;
      push(5'd7, 32'h77);
      step();
      quiet();
      @(negedge clk);
      chk("haz_pend_a_buf", {31'b0, bus.pend_a}, 32'd1);
      chk("haz_pend_b_zero", {31'b0, bus.pend_b}, 32'd0);
      step();
      @(negedge clk);
      chk("haz_pend_a_out", {31'b0, bus.pend_a}, 32'd1);
      step();
      @(negedge clk);
      chk("haz_pend_a_clear", {31'b0, bus.pend_a}, 32'd0);
      bus.rna = 5'd0;
      bus.rnb = 5'd7;
      step();
      bus.a_valid = 1'b1; bus.a_wn = 5'd7; bus.a_d = 32'h78;
      push(5'd7, 32'h78);
      step();
      quiet();
      @(negedge clk);
      chk("haz_rna_zero", {31'b0, bus.pend_a}, 32'd0);
      chk("haz_pend_b",   {31'b0, bus.pend_b}, 32'd1);
      repeat (3) step();

      // Same destination from both requesters, pointer at A
      do_reset();
      step();
      bus.a_valid = 1'b1; bus.a_wn = 5'd9; bus.a_d = 32'h1;
      bus.b_valid = 1'b1; bus.b_wn = 5'd9; bus.b_d = 32'h2;
      push(5'd9, 32'h1);
      push(5'd9, 32'h2);
      step();
      quiet();
      repeat (4) step();
      chk("same_addr_r9", regs[9], 32'h2);

      // Asynchronous reset with a write issuing and an entry buffered
      do_reset();
      bus.rna = 5'd10;
      bus.rnb = 5'd11;
      step();
      bus.a_valid = 1'b1; bus.a_wn = 5'd10; bus.a_d = 32'hAA;
      bus.b_valid = 1'b1; bus.b_wn = 5'd11; bus.b_d = 32'hBB;
      step();
      quiet();
      step();
      chk("midrst_pre_we", {31'b0, bus.we}, 32'd1);
      clrn = 1'b0;
      #1;
      chk("midrst_we",      {31'b0, bus.we},      32'd0);
      chk("midrst_wn",      {27'b0, bus.wn},      32'd0);
      chk("midrst_d",       bus.d,                32'd0);
      chk("midrst_idle",    {31'b0, bus.idle},    32'd1);
      chk("midrst_a_ready", {31'b0, bus.a_ready}, 32'd1);
      chk("midrst_b_ready", {31'b0, bus.b_ready}, 32'd1);
      chk("midrst_pend_a",  {31'b0, bus.pend_a},  32'd0);
      chk("midrst_pend_b",  {31'b0, bus.pend_b},  32'd0);
      repeat (2) step();
      clrn = 1'b1;
      repeat (3) step();
      chk("midrst_after_idle", {31'b0, bus.idle}, 32'd1);

      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
